// File: rtl/conv3x3_stream.sv
// 3x3 streaming convolution: signed weight load FSM, 4-stage multiply/sum/shift/clamp pipeline.
// Optional CONV_ABS_EN macro builds the absolute-value stage used by edge-detection kernels.
module conv3x3_stream #(
  parameter  int DATA_WIDTH   = 8,
  parameter  int WEIGHT_WIDTH = 4,
  localparam int ACC_WIDTH    = DATA_WIDTH + WEIGHT_WIDTH + 5
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [9*DATA_WIDTH-1:0]     s_data,
  input  logic                        s_valid,
  output logic                        s_ready,
  input  logic                        i_EOL,
  input  logic                        i_tlast,
  output logic [DATA_WIDTH-1:0]       m_data,
  output logic                        m_valid,
  input  logic                        m_ready,
  output logic                        o_EOL,
  output logic                        o_tlast,
  input  logic                        start,
  input  logic [9*WEIGHT_WIDTH-1:0]   filter_weights,
  input  logic [3:0]                  norm_shift,
  input  logic                        abs_mode,
  output logic                        cfg_busy,
  output logic [WEIGHT_WIDTH+3:0]     cfg_wsum
);

  localparam int PW = DATA_WIDTH + WEIGHT_WIDTH + 1;
  localparam int SW = WEIGHT_WIDTH + 4;
  localparam logic signed [ACC_WIDTH-1:0] PIX_MAX = ACC_WIDTH'((1 << DATA_WIDTH) - 1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_LOAD  = 2'd1;
  localparam logic [1:0] ST_READY = 2'd2;

  logic [1:0]                     state_q, state_d;
  logic [3:0]                     cnt_q, cnt_d;
  logic signed [WEIGHT_WIDTH-1:0] kernel_q [9];
  logic signed [WEIGHT_WIDTH-1:0] kernel_d [9];
  logic signed [SW-1:0]           wsum_q, wsum_d;
  logic [9*WEIGHT_WIDTH-1:0]      shw_q, shw_d;
  logic [3:0]                     sh_shift_q, sh_shift_d, act_shift_q, act_shift_d;
  logic                           sh_abs_q, sh_abs_d, act_abs_q, act_abs_d;
  logic                           abs_cfg;
  logic signed [WEIGHT_WIDTH-1:0] cur_w;

  // Pipeline registers: stage 1 products, stage 2 sum, stage 3 shifted, stage 4 clamped output.
  logic signed [PW-1:0]        prod_q [9];
  logic signed [PW-1:0]        prod_d [9];
  logic signed [ACC_WIDTH-1:0] sum_q, sum_d, r_q, r_d;
  logic [DATA_WIDTH-1:0]       m_data_q, m_data_d;
  logic                        v1_q, v2_q, v3_q, m_valid_q;
  logic                        eol1_q, eol2_q, eol3_q, eol4_q;
  logic                        tl1_q, tl2_q, tl3_q, tl4_q;
  logic [3:0]                  shift1_q, shift2_q;
  logic                        abs1_q, abs2_q;
  logic                        adv;

`ifdef CONV_ABS_EN
  assign abs_cfg = abs_mode;
`else
  logic unused_abs;
  assign abs_cfg    = 1'b0;
  assign unused_abs = abs_mode ^ abs2_q;
`endif

  assign adv      = !m_valid_q || m_ready;
  assign s_ready  = (state_q == ST_READY) && adv;
  assign cfg_busy = (state_q == ST_LOAD);
  assign cfg_wsum = wsum_q;
  assign m_data   = m_data_q;
  assign m_valid  = m_valid_q;
  assign o_EOL    = eol4_q;
  assign o_tlast  = tl4_q;
  assign cur_w    = shw_q[cnt_q*WEIGHT_WIDTH +: WEIGHT_WIDTH];

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    wsum_d      = wsum_q;
    shw_d       = shw_q;
    sh_shift_d  = sh_shift_q;
    sh_abs_d    = sh_abs_q;
    act_shift_d = act_shift_q;
    act_abs_d   = act_abs_q;
    kernel_d    = kernel_q;
    case (state_q)
      ST_IDLE, ST_READY: begin
        if (start) begin
          shw_d      = filter_weights;
          sh_shift_d = norm_shift;
          sh_abs_d   = abs_cfg;
          cnt_d      = 4'd0;
          wsum_d     = '0;
          state_d    = ST_LOAD;
        end
      end
      ST_LOAD: begin
        kernel_d[cnt_q] = cur_w;
        wsum_d = wsum_q + {{4{cur_w[WEIGHT_WIDTH-1]}}, cur_w};
        // Normalisation settings switch together with the last weight so in-flight beats keep the old ones.
        if (cnt_q == 4'd8) begin
          state_d     = ST_READY;
          act_shift_d = sh_shift_q;
          act_abs_d   = sh_abs_q;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    for (int k = 0; k < 9; k++) begin
      prod_d[k] = $signed({1'b0, s_data[k*DATA_WIDTH +: DATA_WIDTH]}) * kernel_q[k];
    end
    sum_d = '0;
    for (int k = 0; k < 9; k++) begin
      sum_d = sum_d + ACC_WIDTH'(prod_q[k]);
    end
  end

  always_comb begin
    r_d = sum_q >>> shift2_q;
`ifdef CONV_ABS_EN
    if (abs2_q && r_d[ACC_WIDTH-1]) r_d = -r_d;
`endif
    if (r_q[ACC_WIDTH-1])    m_data_d = '0;
    else if (r_q > PIX_MAX)  m_data_d = PIX_MAX[DATA_WIDTH-1:0];
    else                     m_data_d = r_q[DATA_WIDTH-1:0];
  end

  // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= 4'd0;
      wsum_q      <= '0;
      shw_q       <= '0;
      sh_shift_q  <= 4'd0;
      sh_abs_q    <= 1'b0;
      act_shift_q <= 4'd0;
      act_abs_q   <= 1'b0;
      // NOTE: the kernel and product arrays are tiny register files, so they are reset like any flop.
      for (int k = 0; k < 9; k++) begin
        kernel_q[k] <= '0;
        prod_q[k]   <= '0;
      end
      sum_q     <= '0;
      r_q       <= '0;
      m_data_q  <= '0;
      {v1_q, v2_q, v3_q, m_valid_q} <= 4'b0;
      {eol1_q, eol2_q, eol3_q, eol4_q} <= 4'b0;
      {tl1_q, tl2_q, tl3_q, tl4_q} <= 4'b0;
      shift1_q  <= 4'd0;
      shift2_q  <= 4'd0;
      abs1_q    <= 1'b0;
      abs2_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      wsum_q      <= wsum_d;
      shw_q       <= shw_d;
      sh_shift_q  <= sh_shift_d;
      sh_abs_q    <= sh_abs_d;
      act_shift_q <= act_shift_d;
      act_abs_q   <= act_abs_d;
      kernel_q    <= kernel_d;
      if (adv) begin
        prod_q    <= prod_d;
        v1_q      <= s_valid && s_ready;
        eol1_q    <= i_EOL;
        tl1_q     <= i_tlast;
        shift1_q  <= act_shift_q;
        abs1_q    <= act_abs_q;
        sum_q     <= sum_d;
        v2_q      <= v1_q;
        eol2_q    <= eol1_q;
        tl2_q     <= tl1_q;
        shift2_q  <= shift1_q;
        abs2_q    <= abs1_q;
        r_q       <= r_d;
        v3_q      <= v2_q;
        eol3_q    <= eol2_q;
        tl3_q     <= tl2_q;
        m_data_q  <= m_data_d;
        m_valid_q <= v3_q;
        eol4_q    <= eol3_q;
        tl4_q     <= tl3_q;
      end
    end
  end

endmodule

// File: tb/tb_conv3x3_stream.sv
// Directed self-checking bench for conv3x3_stream: config loads, kernels, saturation, stalls, reload, reset.
module tb_conv3x3_stream;

  logic        clk;
  logic        rst;
  logic [71:0] s_data;
  logic        s_valid;
  logic        s_ready;
  logic        i_EOL;
  logic        i_tlast;
  logic [7:0]  m_data;
  logic        m_valid;
  logic        m_ready;
  logic        o_EOL;
  logic        o_tlast;
  logic        start;
  logic [35:0] filter_weights;
  logic [3:0]  norm_shift;
  logic        abs_mode;
  logic        cfg_busy;
  logic [7:0]  cfg_wsum;

  int n_checks = 0;
  int n_pass   = 0;

  conv3x3_stream dut (
    .clk(clk), .rst(rst),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .i_EOL(i_EOL), .i_tlast(i_tlast),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
    .o_EOL(o_EOL), .o_tlast(o_tlast),
    .start(start), .filter_weights(filter_weights), .norm_shift(norm_shift),
    .abs_mode(abs_mode), .cfg_busy(cfg_busy), .cfg_wsum(cfg_wsum)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // Corner pixels k=0,2,6,8; edge pixels k=1,3,5,7; centre k=4.
  function automatic logic [71:0] pix3(input logic [7:0] c, input logic [7:0] e, input logic [7:0] m);
    logic [71:0] v;
    for (int k = 0; k < 9; k++) v[k*8 +: 8] = (k == 4) ? m : ((k % 2) == 1) ? e : c;
    return v;
  endfunction

  function automatic logic [35:0] wts(input logic [3:0] c, input logic [3:0] e, input logic [3:0] m);
    logic [35:0] v;
    for (int k = 0; k < 9; k++) v[k*4 +: 4] = (k == 4) ? m : ((k % 2) == 1) ? e : c;
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [35:0] w, input logic [3:0] sh, input logic ab, input logic [7:0] exp_wsum);
    int busy_cnt;
    filter_weights = w;
    norm_shift     = sh;
    abs_mode       = ab;
    start          = 1'b1;
    tick();
    start    = 1'b0;
    busy_cnt = 0;
    for (int c = 0; c < 20; c++) begin
      if (!cfg_busy) break;
      busy_cnt++;
      tick();
    end
    check("load_busy_cycles", 32'(busy_cnt), 32'd9);
    check("load_s_ready", 32'(s_ready), 32'd1);
    check("load_wsum", 32'(cfg_wsum), 32'(exp_wsum));
  endtask

  task automatic send_beat(input string tag, input logic [71:0] pix, input logic [7:0] exp);
    s_valid = 1'b1;
    s_data  = pix;
    tick();
    s_valid = 1'b0;
    tick();
    tick();
    check({tag, "_latency"}, 32'(m_valid), 32'd0);
    tick();
    check({tag, "_data"}, 32'({m_valid, m_data}), 32'({1'b1, exp}));
    tick();
  endtask

  initial begin
    logic [7:0] exp_q[$];
    int sent, got, ready_low, busy_seen;
    logic acc, st, start_issued, started;

    rst = 1'b1; s_data = '0; s_valid = 1'b0; i_EOL = 1'b0; i_tlast = 1'b0;
    m_ready = 1'b1; start = 1'b0; filter_weights = '0; norm_shift = 4'd0; abs_mode = 1'b0;
    repeat (3) tick();
    check("rst_outputs", 32'({m_valid, m_data, o_EOL, o_tlast, cfg_busy, cfg_wsum, s_ready}), 32'd0);
    rst = 1'b0;
    s_valid = 1'b1;
    tick();
    check("idle_s_ready", 32'(s_ready), 32'd0);
    tick();
    check("idle_m_valid", 32'(m_valid), 32'd0);
    s_valid = 1'b0;

    do_load(wts(4'd0, 4'd0, 4'd1), 4'd0, 1'b0, 8'd1);
    send_beat("identity", pix3(8'd17, 8'd33, 8'd200), 8'd200);

    do_load(wts(4'd1, 4'd1, 4'd1), 4'd3, 1'b0, 8'd9);
    send_beat("ones_shift3", pix3(8'd80, 8'd80, 8'd80), 8'd90);

    do_load(wts(4'd1, 4'd1, 4'd1), 4'd0, 1'b0, 8'd9);
    send_beat("saturate_hi", pix3(8'd255, 8'd255, 8'd255), 8'd255);

    do_load(wts(4'd0, 4'hF, 4'd4), 4'd0, 1'b0, 8'd0);
    send_beat("laplace_clamp0", pix3(8'd99, 8'd50, 8'd10), 8'd0);

    do_load(wts(4'd0, 4'hF, 4'd4), 4'd0, 1'b1, 8'd0);
`ifdef CONV_ABS_EN
    send_beat("laplace_abs", pix3(8'd99, 8'd50, 8'd10), 8'd160);
`else
    send_beat("laplace_abs", pix3(8'd99, 8'd50, 8'd10), 8'd0);
`endif

    // 16-beat stream through the identity kernel with a 5-cycle downstream stall.
    do_load(wts(4'd0, 4'd0, 4'd1), 4'd0, 1'b0, 8'd1);
    got = 0;
    fork
      begin
        sent = 0;
        for (int c = 0; c < 100 && sent < 16; c++) begin
          s_valid = 1'b1;
          s_data  = pix3(8'd3, 8'd3, 8'(10 + sent));
          i_EOL   = (sent == 7) || (sent == 15);
          i_tlast = (sent == 15);
          @(negedge clk);
          acc = s_ready;
          tick();
          if (acc) sent++;
        end
        s_valid = 1'b0; i_EOL = 1'b0; i_tlast = 1'b0;
      end
      begin
        repeat (6) tick();
        m_ready = 1'b0;
        repeat (5) tick();
        m_ready = 1'b1;
      end
      begin
        logic       hold_pending;
        logic [7:0] held;
        hold_pending = 1'b0;
        held = '0;
        for (int c = 0; c < 200 && got < 16; c++) begin
          @(negedge clk);
          if (hold_pending) check("stall_hold", 32'({m_valid, m_data}), 32'({1'b1, held}));
          hold_pending = m_valid && !m_ready;
          held = m_data;
          if (m_valid && m_ready) begin
            check("stream_beat", 32'({o_tlast, o_EOL, m_data}),
                  32'({(got == 15), (got == 7 || got == 15), 8'(10 + got)}));
            got++;
          end
        end
      end
    join
    check("stream_count", 32'(got), 32'd16);
    repeat (4) tick();
    check("stream_no_extra", 32'(m_valid), 32'd0);

    // Reload to all-ones/shift 3 while streaming: beats before the start edge keep identity.
    filter_weights = wts(4'd1, 4'd1, 4'd1);
    norm_shift = 4'd3;
    abs_mode = 1'b0;
    exp_q.delete();
    got = 0; ready_low = 0; busy_seen = 0;
    start_issued = 1'b0; started = 1'b0;
    fork
      begin
        sent = 0;
        s_valid = 1'b1;
        s_data  = pix3(8'd16, 8'd16, 8'd16);
        for (int c = 0; c < 100 && sent < 12; c++) begin
          @(negedge clk);
          acc = s_valid && s_ready;
          st  = start;
          if (!s_ready) ready_low++;
          if (cfg_busy) busy_seen++;
          tick();
          if (acc) begin
            exp_q.push_back(started ? 8'(9 * (sent + 2)) : 8'(8 * (sent + 2)));
            sent++;
          end
          if (st) started = 1'b1;
          start = 1'b0;
          if (sent == 4 && !start_issued) begin
            start = 1'b1;
            start_issued = 1'b1;
          end
          s_data  = pix3(8'(8 * (sent + 2)), 8'(8 * (sent + 2)), 8'(8 * (sent + 2)));
          s_valid = (sent < 12);
        end
        s_valid = 1'b0;
        start = 1'b0;
      end
      begin
        for (int c = 0; c < 200 && got < 12; c++) begin
          @(negedge clk);
          if (m_valid && m_ready) begin
            if (exp_q.size() == 0) check("reload_beat_unexpected", 32'(m_data), 32'd999);
            else check("reload_beat", 32'(m_data), 32'(exp_q.pop_front()));
            got++;
          end
        end
      end
    join
    check("reload_count", 32'(got), 32'd12);
    check("reload_ready_low", 32'(ready_low), 32'd9);
    check("reload_busy", 32'(busy_seen), 32'd9);
    check("reload_wsum", 32'(cfg_wsum), 32'd9);
    repeat (4) tick();

    // Reset during the fourth LOAD cycle.
    filter_weights = wts(4'd1, 4'd1, 4'd1);
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (3) tick();
    check("mid_load_busy", 32'(cfg_busy), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst_load_outputs", 32'({s_ready, m_valid, cfg_busy, cfg_wsum}), 32'd0);
    do_load(wts(4'd1, 4'd1, 4'd1), 4'd3, 1'b0, 8'd9);
    send_beat("post_rst", pix3(8'd80, 8'd80, 8'd80), 8'd90);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
